clock_div_n: RTL and testbench
==============================

CLOCK_DIV_N -- requirements
Module: clock_div_n

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the divide-ratio input and internal counter.
REQ-002 The block SHALL have parameter RST_EN, default 0, giving the value of the internal run state after reset.
REQ-003 clk  input  1  the single clock; all state is clocked by clk.
REQ-004 rstn  input  1  reset, asynchronous and active-low; the reset input is named rstn.
REQ-005 en  input  1  run request; sampled only at period boundaries.
REQ-006 div_val  input  CNT_W  requested divide ratio N; sampled only at period boundaries.
REQ-007 clk_div  output  1  divided clock, frequency clk/N, duty 50% for even and odd N.
REQ-008 tick  output  1  one-clk-cycle pulse coincident with each clk_div rising edge.
REQ-009 ratio  output  CNT_W  divide ratio currently in effect.

Function
REQ-010 The block SHALL hold an active ratio register N_act, a counter cnt (0..N_act-1) and a run flag; N_act and run SHALL be reloaded only at a boundary.
REQ-011 A boundary SHALL be any clk edge where run=0, or where run=1 and cnt==N_act-1.
REQ-012 At a boundary the block SHALL load N_act from div_val, clamping values 0 and 1 to 2, and load run from en.
REQ-013 When run=1 the block SHALL increment cnt each clk, wrapping from N_act-1 to 0; when run=0 it SHALL hold cnt=0.
REQ-014 A posedge-register hi_p SHALL be 1 when run=1 and the next cnt is less than ceil(N_act/2); otherwise 0.
REQ-015 A negedge-register hi_n SHALL capture hi_p on every falling edge of clk.
REQ-016 For even N_act, clk_div SHALL equal hi_p; for odd N_act, clk_div SHALL equal hi_p AND hi_n, giving a high time of N_act/2 clk periods.
REQ-017 The even/odd select SHALL come from registered N_act, never from div_val directly, so that clk_div cannot glitch.
REQ-018 tick SHALL be 1 for exactly the clk cycle in which cnt==0 and run=1.
REQ-019 ratio SHALL equal N_act at all times.
REQ-020 Changing div_val mid-period SHALL NOT affect the current period; the new value SHALL apply from the next period's first cycle.
REQ-021 Deasserting en mid-period SHALL let the current period finish in full; clk_div SHALL then remain 0 with no runt pulse.
REQ-022 Asserting en while stopped SHALL start the counter at the next clk edge, with the first clk_div rising edge and tick in the cycle after that edge.
REQ-023 When N_act=2 the block SHALL produce clk_div toggling every clk cycle and tick every second cycle.
REQ-024 div_val at its maximum (2^CNT_W-1) SHALL be supported without counter overflow.

Reset
REQ-025 While rstn=0 the block SHALL force cnt=0, N_act=2, run=RST_EN, hi_p=0, hi_n=0, so that clk_div=0, tick=0, ratio=2.
REQ-026 Reset assertion mid-period SHALL take effect immediately, asynchronously, without waiting for a boundary.
REQ-027 After rstn deasserts, the first edge SHALL be treated as a boundary.

Verification
REQ-028 Reset then en=1 and div_val=4 -> clk_div is 2 clk high and 2 clk low; tick once every 4 cycles; ratio=4.
REQ-029 div_val=3 -> clk_div period is 3 clk with a 1.5-clk high time, measured edge-to-edge on both clk edges; no glitches.
REQ-030 Running at div_val=5, switch div_val to 2 at cnt=1 -> the current 5-cycle period completes intact; the next period is 2 cycles; ratio changes at the boundary.
REQ-031 div_val=0 and div_val=1 -> ratio=2 and clk_div toggles every clk cycle.
REQ-032 Running at div_val=6, drop en at cnt=2 -> the period completes, then clk_div=0 and tick=0 persist; re-assert en -> restart with a full high phase.
REQ-033 Running at div_val=7, assert rstn=0 asynchronously between clk edges -> clk_div=0 and ratio=2 immediately; behaviour after release matches REQ-027.

Source files
------------

// File: rtl/clock_div_n.sv
// rtl/clock_div_n.sv - programmable integer clock divider, 50% duty for even and odd ratios
module clock_div_n #(
  parameter int   CNT_W  = 8,
  parameter logic RST_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_div,
  output logic             tick,
  output logic [CNT_W-1:0] ratio
);

  // Run flag kept as a two-state machine: stopped or counting.
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t           ST_RST = state_t'(RST_EN);
  localparam logic [CNT_W-1:0] N_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0] N_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_n_act;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] w_half_nxt;
  logic [CNT_W-1:0] w_div_clamped;
  logic             r_first;
  logic             r_hi_p;
  logic             w_hi_p_nxt;
  logic             r_hi_n;
  logic             w_run;
  logic             w_boundary;

  assign w_run = (r_state == ST_RUN);

  // Ratios below 2 cannot form a clock; treat them as the fastest legal ratio.
  assign w_div_clamped = (div_val < N_MIN) ? N_MIN : div_val;

  // A period boundary: first edge out of reset, any edge while stopped, or the last count.
  assign w_boundary = r_first || !w_run || (r_cnt == (r_n_act - N_ONE));

  // Next-state: ratio and run are only reloaded at a boundary; hi_p looks at the next count.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n_act;
    w_cnt_nxt   = r_cnt;
    if (w_boundary) begin
      w_n_nxt     = w_div_clamped;
      w_state_nxt = en ? ST_RUN : ST_STOP;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt + N_ONE;
    end
    // ceil(N/2): the number of cycles hi_p stays high in each period
    w_half_nxt = (w_n_nxt >> 1) + {{(CNT_W-1){1'b0}}, w_n_nxt[0]};
    w_hi_p_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt < w_half_nxt);
  end

  // Rising-edge state: run flag, counter, active ratio and the high-phase register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_n_act <= N_MIN;
      r_hi_p  <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n_act <= w_n_nxt;
      r_hi_p  <= w_hi_p_nxt;
      r_first <= 1'b0;
    end
  end

  // Half-cycle delayed copy of hi_p; ANDing it in trims odd ratios to an exact N/2 high time.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hi_n <= 1'b0;
    end else begin
      r_hi_n <= r_hi_p;
    end
  end

  // Parity comes from the registered ratio so the select only moves while hi_p is being set.
  assign clk_div = r_n_act[0] ? (r_hi_p & r_hi_n) : r_hi_p;
  assign tick    = w_run && !r_first && (r_cnt == '0);
  assign ratio   = r_n_act;

endmodule

// File: tb/tb_clock_div_n.sv
// tb/tb_clock_div_n.sv - directed table-driven bench for clock_div_n
module tb_clock_div_n;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [7:0] div_val;
  logic       clk_div;
  logic       tick;
  logic [7:0] ratio;

  int n_checks = 0;
  int n_pass   = 0;

  logic       sa_clk;
  logic       sa_tick;
  logic [7:0] sa_ratio;
  logic       sb_clk;

  bit     mon_en = 1'b0;
  longint rises[$];
  longint falls[$];

  typedef struct {
    logic       en;
    logic [7:0] div;
    logic       a;
    logic       b;
    logic       tk;
    logic [7:0] rt;
  } vec_t;

  vec_t vecs[$];

  clock_div_n #(
    .CNT_W  (8),
    .RST_EN (1'b0)
  ) u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .div_val (div_val),
    .clk_div (clk_div),
    .tick    (tick),
    .ratio   (ratio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk_div) if (mon_en) rises.push_back($time);
  always @(negedge clk_div) if (mon_en) falls.push_back($time);

  function automatic vec_t v(input int e, input int d, input int a, input int b,
                             input int tk, input int rt);
    vec_t r;
    r.en  = e[0];
    r.div = d[7:0];
    r.a   = a[0];
    r.b   = b[0];
    r.tk  = tk[0];
    r.rt  = rt[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One clk cycle: sample just after the rising edge and just after the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
    sa_clk   = clk_div;
    sa_tick  = tick;
    sa_ratio = ratio;
    @(negedge clk);
    #2;
    sb_clk = clk_div;
  endtask

  task automatic wait_tick(input int maxc, input int r, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      step();
      if (sa_tick && (sa_ratio == r[7:0])) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, " tick_seen"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_hi;
    int b_hi;
    int n_tk;

    // ratio 4
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(v(1, 4, 1, 1, 1, 4));
      vecs.push_back(v(1, 4, 1, 1, 0, 4));
      vecs.push_back(v(1, 4, 0, 0, 0, 4));
      vecs.push_back(v(1, 4, 0, 0, 0, 4));
    end
    // ratio 3: rise lands on the falling edge
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(v(1, 3, 0, 1, 1, 3));
      vecs.push_back(v(1, 3, 1, 1, 0, 3));
      vecs.push_back(v(1, 3, 0, 0, 0, 3));
    end
    // ratio 5, div_val moved to 2 at cnt=1
    vecs.push_back(v(1, 5, 0, 1, 1, 5));
    vecs.push_back(v(1, 5, 1, 1, 0, 5));
    vecs.push_back(v(1, 2, 1, 1, 0, 5));
    vecs.push_back(v(1, 2, 0, 0, 0, 5));
    vecs.push_back(v(1, 2, 0, 0, 0, 5));
    vecs.push_back(v(1, 2, 1, 1, 1, 2));
    vecs.push_back(v(1, 2, 0, 0, 0, 2));
    vecs.push_back(v(1, 2, 1, 1, 1, 2));
    vecs.push_back(v(1, 2, 0, 0, 0, 2));
    // div_val 0 and 1 clamp to 2
    vecs.push_back(v(1, 0, 1, 1, 1, 2));
    vecs.push_back(v(1, 0, 0, 0, 0, 2));
    vecs.push_back(v(1, 1, 1, 1, 1, 2));
    vecs.push_back(v(1, 1, 0, 0, 0, 2));
    // ratio 6, en dropped at cnt=2, then restarted
    vecs.push_back(v(1, 6, 1, 1, 1, 6));
    vecs.push_back(v(1, 6, 1, 1, 0, 6));
    vecs.push_back(v(1, 6, 1, 1, 0, 6));
    for (int i = 0; i < 5; i++) vecs.push_back(v(0, 6, 0, 0, 0, 6));
    vecs.push_back(v(1, 6, 1, 1, 1, 6));
    vecs.push_back(v(1, 6, 1, 1, 0, 6));
    vecs.push_back(v(1, 6, 1, 1, 0, 6));
    vecs.push_back(v(1, 6, 0, 0, 0, 6));

    rstn    = 1'b0;
    en      = 1'b0;
    div_val = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("reset clk_div", clk_div, 0);
    chk("reset tick", tick, 0);
    chk("reset ratio", ratio, 2);

    rstn = 1'b1;
    foreach (vecs[i]) begin
      en      = vecs[i].en;
      div_val = vecs[i].div;
      step();
      chk($sformatf("row%0d clk_div_rise_half", i), sa_clk, vecs[i].a);
      chk($sformatf("row%0d tick", i), sa_tick, vecs[i].tk);
      chk($sformatf("row%0d ratio", i), sa_ratio, vecs[i].rt);
      chk($sformatf("row%0d clk_div_fall_half", i), sb_clk, vecs[i].b);
    end

    // ratio 3 measured edge to edge over exactly three periods
    en      = 1'b1;
    div_val = 8'd3;
    wait_tick(20, 3, "odd3");
    rises.delete();
    falls.delete();
    mon_en = 1'b1;
    #90;
    mon_en = 1'b0;
    chk("odd3 rise_count", rises.size(), 3);
    chk("odd3 fall_count", falls.size(), 3);
    if (rises.size() == 3 && falls.size() == 3) begin
      chk("odd3 period_a", rises[1] - rises[0], 30);
      chk("odd3 period_b", rises[2] - rises[1], 30);
      chk("odd3 high_time", falls[1] - rises[0], 15);
      chk("odd3 low_time", rises[1] - falls[1], 15);
    end

    // maximum ratio 255 over one full period
    div_val = 8'd255;
    wait_tick(20, 255, "max255");
    a_hi = int'(sa_clk);
    b_hi = int'(sb_clk);
    n_tk = int'(sa_tick);
    for (int k = 1; k < 255; k++) begin
      step();
      a_hi += int'(sa_clk);
      b_hi += int'(sb_clk);
      n_tk += int'(sa_tick);
    end
    chk("max255 ticks_per_period", n_tk, 1);
    chk("max255 high_rise_halves", a_hi, 127);
    chk("max255 high_fall_halves", b_hi, 128);
    step();
    chk("max255 next_tick", sa_tick, 1);
    chk("max255 ratio", sa_ratio, 255);

    // asynchronous reset in the middle of a ratio-7 high phase
    div_val = 8'd7;
    wait_tick(300, 7, "rst7");
    step();
    chk("rst7 pre clk_div_rise_half", sa_clk, 1);
    chk("rst7 pre clk_div_fall_half", sb_clk, 1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst7 async clk_div", clk_div, 0);
    chk("rst7 async ratio", ratio, 2);
    chk("rst7 async tick", tick, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst7 held clk_div", clk_div, 0);
    chk("rst7 held ratio", ratio, 2);
    rstn = 1'b1;
    step();
    chk("rst7 first clk_div_rise_half", sa_clk, 0);
    chk("rst7 first tick", sa_tick, 1);
    chk("rst7 first ratio", sa_ratio, 7);
    chk("rst7 first clk_div_fall_half", sb_clk, 1);
    step();
    chk("rst7 second clk_div_rise_half", sa_clk, 1);
    chk("rst7 second tick", sa_tick, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
